// File: rtl/minipic_pkg.sv
// minipic_pkg: shared constants for the minipic interrupt controller
//   SEL_*   : cfg_sel register codes (1 is reserved)
//   state_t : FSM state encoding
package minipic_pkg;
   localparam logic [1:0] SEL_ENABLE   = 2'd0;
   localparam logic [1:0] SEL_PEND_CLR = 2'd2;
   localparam logic [1:0] SEL_OVF_CLR  = 2'd3;
   typedef enum logic {ST_IDLE, ST_PRESENT} state_t;
endpackage

// File: rtl/minipic_prio_enc.sv
// minipic_prio_enc: combinational lowest-index priority encoder
//   req [NUM_SRC] : request vector
//   idx [ID_W]    : index of the lowest set bit (0 when none)
//   any           : at least one request set
module minipic_prio_enc #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_SRC-1:0] req,
   output logic [ID_W-1:0]    idx,
   output logic               any
);
   always_comb begin
      idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (req[i]) idx = ID_W'(i);
   end
   assign any = |req;
endmodule

// File: rtl/minipic.sv
// minipic: small interrupt controller with edge capture, masking and lowest-index priority
//   clk, rst_n (sync, active-low), enable (global enable)
//   irq_in [NUM_SRC]        : edge-detected request lines
//   cfg_we/cfg_sel/cfg_data : register writes (ENABLE, PEND_CLR, OVF_CLR)
//   irq_ack                 : host acknowledge, honoured only while presenting
//   irq_out, irq_id         : presented interrupt and its source index
//   pending, overflow       : status, zero-extended to 8 bits
// Optional build macro MINIPIC_OVERFLOW_EN adds sticky overflow flags.
module minipic
   import minipic_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_sel,
   input  logic [7:0]         cfg_data,
   input  logic               irq_ack,
   output logic               irq_out,
   output logic [ID_W-1:0]    irq_id,
   output logic [7:0]         pending,
   output logic [7:0]         overflow
);
   state_t             state;
   logic [NUM_SRC-1:0] irq_in_q, pend, en_reg, rise, clr, active;
   logic [ID_W-1:0]    win;
   logic               any;

   // capture is fully suppressed while the block is globally disabled
   assign rise   = enable ? irq_in & ~irq_in_q : '0;
   assign clr    = ((cfg_we && cfg_sel == SEL_PEND_CLR) ? cfg_data[NUM_SRC-1:0] : '0)
                 | ((enable && state == ST_PRESENT && irq_ack) ? NUM_SRC'(1) << irq_id : '0);
   assign active = pend & en_reg;

   minipic_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_prio (
      .req(active),
      .idx(win),
      .any(any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_in_q <= '0;
         pend     <= '0;
         en_reg   <= '0;
      end else begin
         if (enable) irq_in_q <= irq_in;
         pend <= (pend & ~clr) | rise;
         if (cfg_we && cfg_sel == SEL_ENABLE) en_reg <= cfg_data[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         irq_out <= 1'b0;
         irq_id  <= '0;
      end else if (!enable) begin
         state   <= ST_IDLE;
         irq_out <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:
               if (any) begin
                  state   <= ST_PRESENT;
                  irq_out <= 1'b1;
                  irq_id  <= win;
               end
            ST_PRESENT:
               // withdraw when acked, masked off, or cleared from under us
               if (irq_ack || !en_reg[irq_id] || !pend[irq_id]) begin
                  state   <= ST_IDLE;
                  irq_out <= 1'b0;
               end
            default: begin
               state   <= ST_IDLE;
               irq_out <= 1'b0;
            end
         endcase
      end
   end

   assign pending = 8'(pend);

`ifdef MINIPIC_OVERFLOW_EN
   logic [NUM_SRC-1:0] ovf;
   always_ff @(posedge clk) begin
      if (!rst_n) ovf <= '0;
      else ovf <= (ovf & ~((cfg_we && cfg_sel == SEL_OVF_CLR) ? cfg_data[NUM_SRC-1:0] : '0))
                | (rise & pend & ~clr);
   end
   assign overflow = 8'(ovf);
`else
   assign overflow = '0;
`endif
endmodule

// File: tb/tb_minipic.sv
// tb_minipic: directed self-checking bench for minipic (NUM_SRC=4)
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
//   Overflow expectations follow MINIPIC_OVERFLOW_EN when it is defined.
module tb_minipic;
   logic       clk = 1'b0;
   logic       rst_n, enable, cfg_we, irq_ack, irq_out;
   logic [3:0] irq_in;
   logic [1:0] cfg_sel, irq_id;
   logic [7:0] cfg_data, pending, overflow;
   int         tests = 0, fails = 0;
`ifdef MINIPIC_OVERFLOW_EN
   localparam logic [7:0] OVF_EXP = 8'h01;
`else
   localparam logic [7:0] OVF_EXP = 8'h00;
`endif

   minipic dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .irq_in(irq_in),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .irq_ack(irq_ack),
      .irq_out(irq_out), .irq_id(irq_id), .pending(pending), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [1:0] sel, input logic [7:0] data);
      cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
      tick();
      cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'h00;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] v);
      irq_in = v;
      tick();
      irq_in = 4'h0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; irq_in = 4'h0; cfg_we = 1'b0;
      cfg_sel = 2'd0; cfg_data = 8'h00; irq_ack = 1'b0;
      tick(); tick();
      rst_n = 1'b1; enable = 1'b1;
      chk("rst_out", {7'd0, irq_out}, 8'h00);
      chk("rst_id", {6'd0, irq_id}, 8'h00);
      chk("rst_pend", pending, 8'h00);
      chk("rst_ovf", overflow, 8'h00);
      // single source, two-cycle latency, ack
      cfg(2'd0, 8'h01);
      pulse(4'h1);
      chk("t1_pend", pending, 8'h01);
      chk("t1_out_n1", {7'd0, irq_out}, 8'h00);
      tick();
      chk("t1_out", {7'd0, irq_out}, 8'h01);
      chk("t1_id", {6'd0, irq_id}, 8'h00);
      ack();
      chk("t1_ack_out", {7'd0, irq_out}, 8'h00);
      chk("t1_ack_pend", pending, 8'h00);
      tick();
      chk("t1_idle", {7'd0, irq_out}, 8'h00);
      // priority between simultaneous sources
      cfg(2'd0, 8'h0F);
      pulse(4'h6);
      chk("t2_pend", pending, 8'h06);
      tick();
      chk("t2_out1", {7'd0, irq_out}, 8'h01);
      chk("t2_id1", {6'd0, irq_id}, 8'h01);
      ack();
      chk("t2_gap", {7'd0, irq_out}, 8'h00);
      chk("t2_pend2", pending, 8'h04);
      tick();
      chk("t2_out2", {7'd0, irq_out}, 8'h01);
      chk("t2_id2", {6'd0, irq_id}, 8'h02);
      ack();
      chk("t2_done", pending, 8'h00);
      ack();
      chk("idle_ack_out", {7'd0, irq_out}, 8'h00);
      chk("idle_ack_pend", pending, 8'h00);
      // masked capture, later unmask, then PEND_CLR withdrawal
      cfg(2'd0, 8'h00);
      pulse(4'h8);
      chk("t3_pend", pending, 8'h08);
      tick();
      chk("t3_masked", {7'd0, irq_out}, 8'h00);
      cfg(2'd0, 8'h08);
      chk("t3_pre", {7'd0, irq_out}, 8'h00);
      tick();
      chk("t3_out", {7'd0, irq_out}, 8'h01);
      chk("t3_id", {6'd0, irq_id}, 8'h03);
      cfg(2'd2, 8'h08);
      chk("t3_clr_pend", pending, 8'h00);
      tick();
      chk("t3_withdraw", {7'd0, irq_out}, 8'h00);
      // mask off during PRESENT
      cfg(2'd0, 8'h01);
      pulse(4'h1);
      tick();
      chk("t4_out", {7'd0, irq_out}, 8'h01);
      cfg(2'd0, 8'h00);
      tick();
      chk("t4_drop", {7'd0, irq_out}, 8'h00);
      chk("t4_pend", pending, 8'h01);
      cfg(2'd1, 8'h0F);
      tick();
      chk("t4_resv", {7'd0, irq_out}, 8'h00);
      cfg(2'd2, 8'h01);
      chk("t4_clr", pending, 8'h00);
      // held level sets pending only once
      cfg(2'd0, 8'h0F);
      irq_in = 4'h2;
      tick();
      chk("lvl_pend", pending, 8'h02);
      tick();
      chk("lvl_id", {6'd0, irq_id}, 8'h01);
      ack();
      chk("lvl_noreset", pending, 8'h00);
      tick();
      chk("lvl_idle", {7'd0, irq_out}, 8'h00);
      irq_in = 4'h0;
      tick();
      // ack coincides with a fresh edge on the same source
      pulse(4'h2);
      tick();
      chk("t5_out", {7'd0, irq_out}, 8'h01);
      irq_ack = 1'b1; irq_in = 4'h2;
      tick();
      irq_ack = 1'b0; irq_in = 4'h0;
      chk("t5_pend", pending, 8'h02);
      chk("t5_gap", {7'd0, irq_out}, 8'h00);
      tick();
      chk("t5_repr", {7'd0, irq_out}, 8'h01);
      chk("t5_id", {6'd0, irq_id}, 8'h01);
      chk("t5_noovf", overflow, 8'h00);
      ack();
      // no pre-emption by a higher-priority arrival
      pulse(4'h4);
      tick();
      pulse(4'h1);
      chk("np_id", {6'd0, irq_id}, 8'h02);
      chk("np_pend", pending, 8'h05);
      ack();
      chk("np_gap", {7'd0, irq_out}, 8'h00);
      tick();
      chk("np_id0", {6'd0, irq_id}, 8'h00);
      chk("np_out0", {7'd0, irq_out}, 8'h01);
      ack();
      // overflow on a second edge while still pending
      pulse(4'h1);
      tick();
      pulse(4'h1);
      chk("t6_ovf", overflow, OVF_EXP);
      cfg(2'd3, 8'h01);
      chk("t6_ovf_clr", overflow, 8'h00);
      ack();
      chk("t6_pend", pending, 8'h00);
      // global enable low drops the interrupt, then reset mid-PRESENT
      pulse(4'h8);
      tick();
      chk("ge_id", {6'd0, irq_id}, 8'h03);
      enable = 1'b0;
      tick();
      chk("ge_drop", {7'd0, irq_out}, 8'h00);
      chk("ge_pend", pending, 8'h08);
      enable = 1'b1;
      tick();
      chk("ge_repr", {7'd0, irq_out}, 8'h01);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst2_out", {7'd0, irq_out}, 8'h00);
      chk("rst2_id", {6'd0, irq_id}, 8'h00);
      chk("rst2_pend", pending, 8'h00);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
